// File: rtl/zpu_sd_bridge.sv
// zpu_sd_bridge: ZPU register ports to HPS virtual-disk bridge with sector buffer,
// per-drive request FSM with timeout, and a pending-mount event queue.
module zpu_sd_bridge #(
  parameter int          NUM_DRIVES = 3,
  parameter int          BUF_AW     = 9,
  parameter logic [7:0]  RO_MASK    = 8'b0000_0100,
  parameter logic [23:0] TIMEOUT    = 24'd10000000
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic [31:0]           zpu_out2,
  input  logic [31:0]           zpu_out3,
  input  logic                  zpu_io_wr,
  input  logic                  zpu_data_wr,
  input  logic                  zpu_data_rd,
  output logic [15:0]           zpu_in2,
  output logic [31:0]           zpu_in3,
  output logic [31:0]           sd_lba,
  output logic [NUM_DRIVES-1:0] sd_rd,
  output logic [NUM_DRIVES-1:0] sd_wr,
  input  logic                  sd_ack,
  input  logic [BUF_AW-1:0]     sd_buff_addr,
  input  logic [7:0]            sd_buff_dout,
  output logic [7:0]            sd_buff_din,
  input  logic                  sd_buff_wr,
  input  logic [NUM_DRIVES-1:0] img_mounted,
  input  logic                  img_readonly,
  input  logic [63:0]           img_size,
  input  logic [7:0]            ioctl_index
);
  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
  state_t state;
  logic lba_sel, blk_rd, blk_wr, m_ack;
  logic [2:0] drv, low, ev_no;
  logic dwr_q1, dwr_q2, drd_q, inc_q, blk_rd_q, blk_wr_q, ack_q, mack_q;
  logic wr_edge, rd_fall, rd_rise, wr_rise, mack_rise, drv_ok, drv_ro;
  logic [BUF_AW-1:0] ptr;
  logic [7:0] buf_q;
  logic [7:0] mem [1<<BUF_AW];
  logic [23:0] cnt;
  logic io_done, io_error, mount_toggle, ev_ro, slot_busy;
  logic [1:0] ev_type;
  logic [31:0] ev_size;
  logic [7:0] pending, ro_l, mounted, clr;
  logic [31:0] size_l [8];
  logic [1:0] type_l [8];
  logic unused_bits;
  assign lba_sel     = zpu_out2[0];
  assign blk_rd      = zpu_out2[1];
  assign blk_wr      = zpu_out2[2];
  assign drv         = zpu_out2[5:3];
  assign m_ack       = zpu_out2[6];
  assign unused_bits = &{1'b0, zpu_out2[31:7], img_size[63:32], ioctl_index[5:0]};
  assign wr_edge   = dwr_q1 & ~dwr_q2;
  assign rd_fall   = drd_q & ~zpu_data_rd;
  assign rd_rise   = blk_rd & ~blk_rd_q;
  assign wr_rise   = blk_wr & ~blk_wr_q;
  assign mack_rise = m_ack & ~mack_q;
  assign drv_ok    = {1'b0, drv} < 4'(NUM_DRIVES);
  assign drv_ro    = RO_MASK[drv] | ro_l[drv];
  assign mounted   = 8'(img_mounted);
  assign clr       = (!slot_busy && |pending) ? 8'(1) << low : 8'd0;
  assign zpu_in2   = {5'd0, ev_no, 2'd0, ev_type, ev_ro, io_error, mount_toggle, io_done};
  always_comb begin
    low = '0;
    for (int i = 7; i >= 0; i--) if (pending[i]) low = 3'(i);
  end
  // Buffer RAM has no reset; both ports read with one cycle of latency.
  always_ff @(posedge clk_sys) begin
    if (wr_edge && !lba_sel) mem[ptr] <= zpu_out3[7:0];
    if (sd_buff_wr) mem[sd_buff_addr] <= sd_buff_dout;
    buf_q       <= mem[ptr];
    sd_buff_din <= mem[sd_buff_addr];
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dwr_q1  <= 1'b0;
      dwr_q2  <= 1'b0;
      drd_q   <= 1'b0;
      inc_q   <= 1'b0;
      ptr     <= '0;
      sd_lba  <= '0;
      zpu_in3 <= '0;
    end else begin
      dwr_q1  <= zpu_data_wr;
      dwr_q2  <= dwr_q1;
      drd_q   <= zpu_data_rd;
      inc_q   <= wr_edge & ~lba_sel;
      sd_lba  <= (wr_edge && lba_sel) ? zpu_out3 : sd_lba;
      ptr     <= zpu_io_wr ? '0 : (inc_q || rd_fall) ? ptr + BUF_AW'(1) : ptr;
      zpu_in3 <= lba_sel ? ev_size : {24'd0, buf_q};
    end
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      io_done  <= 1'b1;
      io_error <= 1'b0;
      sd_rd    <= '0;
      sd_wr    <= '0;
      cnt      <= '0;
      blk_rd_q <= 1'b0;
      blk_wr_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      blk_rd_q <= blk_rd;
      blk_wr_q <= blk_wr;
      ack_q    <= sd_ack;
      case (state)
        IDLE: if (rd_rise || wr_rise) begin
          if (!drv_ok || (!rd_rise && drv_ro)) io_error <= 1'b1;
          else begin
            io_done  <= 1'b0;
            io_error <= 1'b0;
            cnt      <= '0;
            state    <= REQ;
            if (rd_rise) sd_rd <= NUM_DRIVES'(1) << drv;
            else sd_wr <= NUM_DRIVES'(1) << drv;
          end
        end
        REQ: if (sd_ack) begin
          sd_rd <= '0;
          sd_wr <= '0;
          state <= XFER;
        end else if (cnt >= TIMEOUT - 24'd1) begin
          sd_rd    <= '0;
          sd_wr    <= '0;
          io_error <= 1'b1;
          io_done  <= 1'b1;
          state    <= IDLE;
        end else cnt <= cnt + 24'd1;
        XFER: if (ack_q && !sd_ack) begin
          io_done <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // A fresh mount in the same cycle as presentation re-arms the drive's pending bit.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pending      <= '0;
      ro_l         <= '0;
      slot_busy    <= 1'b0;
      mack_q       <= 1'b0;
      mount_toggle <= 1'b0;
      ev_no        <= '0;
      ev_ro        <= 1'b0;
      ev_type      <= '0;
      ev_size      <= '0;
      for (int i = 0; i < 8; i++) begin
        size_l[i] <= '0;
        type_l[i] <= '0;
      end
    end else begin
      mack_q  <= m_ack;
      pending <= (pending & ~clr) | mounted;
      for (int i = 0; i < 8; i++) if (mounted[i]) begin
        size_l[i] <= img_size[31:0];
        ro_l[i]   <= img_readonly | RO_MASK[i];
        type_l[i] <= ioctl_index[7:6];
      end
      if (!slot_busy && |pending) begin
        ev_no        <= low;
        ev_size      <= size_l[low];
        ev_ro        <= ro_l[low];
        ev_type      <= type_l[low];
        mount_toggle <= ~mount_toggle;
        slot_busy    <= 1'b1;
      end else if (mack_rise) slot_busy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_zpu_sd_bridge.sv
// tb_zpu_sd_bridge: randomized scenario bench for zpu_sd_bridge against a
// behavioural model of buffer contents, drive read-only state and mount queue.
module tb_zpu_sd_bridge;
  localparam int ND = 3;
  localparam int AW = 9;
  localparam int TO = 40;
  logic clk_sys = 1'b0, reset_n = 1'b0;
  logic [31:0] zpu_out2, zpu_out3;
  logic zpu_io_wr, zpu_data_wr, zpu_data_rd;
  logic [15:0] zpu_in2;
  logic [31:0] zpu_in3, sd_lba;
  logic [ND-1:0] sd_rd, sd_wr, img_mounted;
  logic sd_ack, sd_buff_wr, img_readonly;
  logic [AW-1:0] sd_buff_addr;
  logic [7:0] sd_buff_dout, sd_buff_din, ioctl_index;
  logic [63:0] img_size;
  int checks = 0, errors = 0;
  logic [7:0] mem_m [512];
  bit exp_tog;
  bit exp_ro [ND];
  bit pend [ND];
  logic [31:0] lat_size [ND];
  bit lat_ro [ND];
  logic [1:0] lat_type [ND];

  zpu_sd_bridge #(.NUM_DRIVES(ND), .BUF_AW(AW), .RO_MASK(8'b0000_0100), .TIMEOUT(24'(TO))) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .zpu_out2(zpu_out2), .zpu_out3(zpu_out3),
    .zpu_io_wr(zpu_io_wr), .zpu_data_wr(zpu_data_wr), .zpu_data_rd(zpu_data_rd),
    .zpu_in2(zpu_in2), .zpu_in3(zpu_in3), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr), .img_mounted(img_mounted),
    .img_readonly(img_readonly), .img_size(img_size), .ioctl_index(ioctl_index));

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [31:0] mk(bit lba, bit rd, bit wr, int drv, bit ack);
    return {25'd0, ack, 3'(drv), wr, rd, lba};
  endfunction

  task automatic cyc(int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic model_reset();
    exp_tog = 1'b0;
    for (int d = 0; d < ND; d++) begin
      exp_ro[d] = 1'b0; pend[d] = 1'b0; lat_size[d] = '0; lat_ro[d] = 1'b0; lat_type[d] = '0;
    end
  endtask

  task automatic mount_pulse(input logic [ND-1:0] m, input logic [31:0] s, input bit r, input logic [1:0] t);
    img_mounted = m; img_size = {$urandom, s}; img_readonly = r; ioctl_index = {t, 6'($urandom)};
    cyc(1);
    img_mounted = '0; img_size = {$urandom, $urandom}; img_readonly = 1'($urandom); ioctl_index = 8'($urandom);
    for (int d = 0; d < ND; d++) if (m[d]) begin
      pend[d] = 1'b1; lat_size[d] = s; lat_ro[d] = r | (d == 2); lat_type[d] = t; exp_ro[d] = lat_ro[d];
    end
  endtask

  task automatic test_reset();
    checks++; if (zpu_in2 !== 16'h0001) begin errors++; $display("FAIL reset_in2 got %h exp 0001", zpu_in2); end
    checks++; if (sd_rd !== '0 || sd_wr !== '0) begin errors++; $display("FAIL reset_req got rd=%b wr=%b exp 0", sd_rd, sd_wr); end
    checks++; if (sd_lba !== '0) begin errors++; $display("FAIL reset_lba got %h exp 0", sd_lba); end
  endtask

  task automatic test_read();
    logic [31:0] lba;
    lba = $urandom;
    zpu_out2 = mk(1, 0, 0, 0, 0); zpu_out3 = lba; cyc(1);
    zpu_data_wr = 1'b1; cyc(1); zpu_data_wr = 1'b0; cyc(3);
    checks++; if (sd_lba !== lba) begin errors++; $display("FAIL read_lba got %h exp %h", sd_lba, lba); end
    for (int i = 0; i < 512; i++) mem_m[i] = 8'($urandom);
    mem_m[0] = ~mem_m[6];
    zpu_out2 = mk(0, 1, 0, 1, 0); cyc(1);
    checks++; if (sd_rd !== 3'b010 || sd_wr !== 3'b000 || zpu_in2[0] !== 1'b0) begin
      errors++; $display("FAIL read_req got rd=%b wr=%b done=%b exp 010 000 0", sd_rd, sd_wr, zpu_in2[0]); end
    sd_ack = 1'b1; cyc(1);
    checks++; if (sd_rd !== 3'b000) begin errors++; $display("FAIL read_ack_clear got %b exp 000", sd_rd); end
    for (int i = 0; i < 512; i++) begin
      sd_buff_wr = 1'b1; sd_buff_addr = AW'(i); sd_buff_dout = mem_m[i]; cyc(1);
    end
    sd_buff_wr = 1'b0;
    checks++; if (zpu_in2[0] !== 1'b0) begin errors++; $display("FAIL read_busy got done=%b exp 0", zpu_in2[0]); end
    sd_ack = 1'b0; cyc(1);
    checks++; if (zpu_in2[0] !== 1'b1 || zpu_in2[2] !== 1'b0) begin
      errors++; $display("FAIL read_done got done=%b err=%b exp 1 0", zpu_in2[0], zpu_in2[2]); end
    zpu_out2 = mk(0, 0, 0, 0, 0); zpu_io_wr = 1'b1; cyc(1); zpu_io_wr = 1'b0; cyc(3);
    for (int i = 0; i <= 512; i++) begin
      checks++; if (zpu_in3 !== {24'd0, mem_m[i % 512]}) begin
        errors++; $display("FAIL readback[%0d] got %h exp %h", i, zpu_in3, mem_m[i % 512]); end
      if (i < 512) begin zpu_data_rd = 1'b1; cyc(1); zpu_data_rd = 1'b0; cyc(4); end
    end
  endtask

  task automatic test_ptr_clear();
    for (int i = 0; i < 5; i++) begin zpu_data_rd = 1'b1; cyc(1); zpu_data_rd = 1'b0; cyc(4); end
    checks++; if (zpu_in3 !== {24'd0, mem_m[5]}) begin errors++; $display("FAIL ptr_adv got %h exp %h", zpu_in3, mem_m[5]); end
    zpu_data_rd = 1'b1; cyc(1);
    zpu_data_rd = 1'b0; zpu_io_wr = 1'b1; cyc(1);
    zpu_io_wr = 1'b0; cyc(3);
    checks++; if (zpu_in3 !== {24'd0, mem_m[0]}) begin errors++; $display("FAIL ptr_clear got %h exp %h", zpu_in3, mem_m[0]); end
  endtask

  task automatic test_zpu_write();
    logic [7:0] b;
    zpu_out2 = mk(0, 0, 0, 0, 0); zpu_io_wr = 1'b1; cyc(1); zpu_io_wr = 1'b0; cyc(1);
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom); mem_m[i] = b; zpu_out3 = $urandom; zpu_out3[7:0] = b;
      zpu_data_wr = 1'b1; cyc(1); zpu_data_wr = 1'b0; cyc(3);
    end
    for (int i = 0; i < 16; i++) begin
      sd_buff_addr = AW'(i); cyc(1);
      checks++; if (sd_buff_din !== mem_m[i]) begin errors++; $display("FAIL hps_read[%0d] got %h exp %h", i, sd_buff_din, mem_m[i]); end
    end
    checks++; if (zpu_in3 !== {24'd0, mem_m[16]}) begin errors++; $display("FAIL wr_ptr got %h exp %h", zpu_in3, mem_m[16]); end
  endtask

  task automatic test_ro_write();
    zpu_out2 = mk(0, 0, 1, 2, 0); cyc(2);
    checks++; if (sd_wr !== 3'b000 || zpu_in2[2] !== 1'b1 || zpu_in2[0] !== 1'b1) begin
      errors++; $display("FAIL ro_write got wr=%b err=%b done=%b exp 000 1 1", sd_wr, zpu_in2[2], zpu_in2[0]); end
    zpu_out2 = mk(0, 0, 0, 0, 0); cyc(1);
  endtask

  task automatic test_bad_drive();
    zpu_out2 = mk(0, 1, 0, 5, 0); cyc(2);
    checks++; if (sd_rd !== 3'b000 || zpu_in2[2] !== 1'b1 || zpu_in2[0] !== 1'b1) begin
      errors++; $display("FAIL bad_drive got rd=%b err=%b done=%b exp 000 1 1", sd_rd, zpu_in2[2], zpu_in2[0]); end
    zpu_out2 = mk(0, 0, 0, 0, 0); cyc(1);
  endtask

  task automatic do_xfer(input bit rd, input int d);
    logic [ND-1:0] oh;
    bit rej;
    oh = ND'(1) << d;
    rej = !rd && (d == 2 || exp_ro[d]);
    zpu_out2 = mk(0, 0, 0, 0, 0); cyc(1);
    zpu_out2 = mk(0, rd, !rd, d, 0); cyc(1);
    if (rej) begin
      checks++; if (sd_wr !== '0 || zpu_in2[2] !== 1'b1 || zpu_in2[0] !== 1'b1) begin
        errors++; $display("FAIL xfer_reject d%0d got wr=%b err=%b done=%b exp 000 1 1", d, sd_wr, zpu_in2[2], zpu_in2[0]); end
    end else begin
      checks++; if (sd_rd !== (rd ? oh : '0) || sd_wr !== (rd ? '0 : oh) || zpu_in2[0] !== 1'b0 || zpu_in2[2] !== 1'b0) begin
        errors++; $display("FAIL xfer_req rd=%0d d%0d got rd=%b wr=%b done=%b err=%b", rd, d, sd_rd, sd_wr, zpu_in2[0], zpu_in2[2]); end
      sd_ack = 1'b1; cyc(1);
      checks++; if (sd_rd !== '0 || sd_wr !== '0) begin errors++; $display("FAIL xfer_clear got rd=%b wr=%b exp 0", sd_rd, sd_wr); end
      cyc($urandom_range(1, 5));
      sd_ack = 1'b0; cyc(1);
      checks++; if (zpu_in2[0] !== 1'b1 || zpu_in2[2] !== 1'b0) begin
        errors++; $display("FAIL xfer_done got done=%b err=%b exp 1 0", zpu_in2[0], zpu_in2[2]); end
    end
    zpu_out2 = mk(0, 0, 0, 0, 0); cyc(1);
  endtask

  task automatic test_timeout();
    zpu_out2 = mk(0, 1, 0, 0, 0); cyc(1);
    checks++; if (sd_rd !== 3'b001 || zpu_in2[2] !== 1'b0) begin errors++; $display("FAIL to_req got rd=%b err=%b exp 001 0", sd_rd, zpu_in2[2]); end
    cyc(TO - 3);
    checks++; if (sd_rd !== 3'b001) begin errors++; $display("FAIL to_hold got %b exp 001", sd_rd); end
    cyc(5);
    checks++; if (sd_rd !== 3'b000 || zpu_in2[2] !== 1'b1 || zpu_in2[0] !== 1'b1) begin
      errors++; $display("FAIL to_expire got rd=%b err=%b done=%b exp 000 1 1", sd_rd, zpu_in2[2], zpu_in2[0]); end
    do_xfer(1'b1, 0);
  endtask

  task automatic test_mount();
    logic [ND-1:0] a, b;
    int lo;
    zpu_out2 = mk(1, 0, 0, 0, 0); cyc(2);
    for (int r = 0; r < 3; r++) begin
      a = ND'($urandom_range(1, 7)); b = ND'($urandom_range(1, 7));
      for (int k = 0; k < 6; k++) begin
        if (k == 0) mount_pulse(a, $urandom, 1'($urandom), 2'($urandom));
        else begin zpu_out2 = mk(1, 0, 0, 0, 1); cyc(1); zpu_out2 = mk(1, 0, 0, 0, 0); end
        cyc(3);
        lo = -1;
        for (int d = ND - 1; d >= 0; d--) if (pend[d]) lo = d;
        if (lo < 0) begin
          checks++; if (zpu_in2[1] !== exp_tog) begin errors++; $display("FAIL mount_idle got tog=%b exp %b", zpu_in2[1], exp_tog); end
          break;
        end
        pend[lo] = 1'b0; exp_tog = ~exp_tog;
        checks++; if (zpu_in2[15:8] !== 8'(lo) || zpu_in2[1] !== exp_tog) begin
          errors++; $display("FAIL mount_ev fileno/tog got %0d/%b exp %0d/%b", zpu_in2[15:8], zpu_in2[1], lo, exp_tog); end
        checks++; if (zpu_in2[3] !== lat_ro[lo] || zpu_in2[5:4] !== lat_type[lo]) begin
          errors++; $display("FAIL mount_ev ro/type got %b/%0d exp %b/%0d", zpu_in2[3], zpu_in2[5:4], lat_ro[lo], lat_type[lo]); end
        checks++; if (zpu_in3 !== lat_size[lo]) begin errors++; $display("FAIL mount_size got %h exp %h", zpu_in3, lat_size[lo]); end
        if (k == 0) begin
          mount_pulse(b, $urandom, 1'($urandom), 2'($urandom)); cyc(3);
          checks++; if (zpu_in2[1] !== exp_tog || zpu_in2[15:8] !== 8'(lo)) begin
            errors++; $display("FAIL mount_hold got tog=%b fileno=%0d exp %b %0d", zpu_in2[1], zpu_in2[15:8], exp_tog, lo); end
        end
      end
    end
    zpu_out2 = mk(0, 0, 0, 0, 0); cyc(1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) do_xfer(1'($urandom), $urandom_range(0, ND - 1));
  endtask

  task automatic test_reset_xfer();
    zpu_out2 = mk(0, 1, 0, 0, 0); cyc(1);
    sd_ack = 1'b1; cyc(2);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    checks++; if (zpu_in2 !== 16'h0001 || sd_rd !== '0 || sd_wr !== '0 || sd_lba !== '0) begin
      errors++; $display("FAIL async_reset got in2=%h rd=%b wr=%b lba=%h exp 0001 0 0 0", zpu_in2, sd_rd, sd_wr, sd_lba); end
    sd_ack = 1'b0; zpu_out2 = mk(0, 0, 0, 0, 0);
    cyc(2); reset_n = 1'b1; cyc(2);
    do_xfer(1'b1, 1);
    do_xfer(1'b0, 1);
  endtask

  initial begin
    zpu_out2 = '0; zpu_out3 = '0; zpu_io_wr = 1'b0; zpu_data_wr = 1'b0; zpu_data_rd = 1'b0;
    sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
    img_mounted = '0; img_readonly = 1'b0; img_size = '0; ioctl_index = '0;
    model_reset();
    cyc(3);
    test_reset();
    reset_n = 1'b1; cyc(2);
    test_reset();
    test_read();
    test_ptr_clear();
    test_zpu_write();
    test_ro_write();
    test_bad_drive();
    test_timeout();
    test_mount();
    test_back_to_back();
    test_reset_xfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
